// File: rtl/risc_pkg.sv
// Shared RiSC-16 encoding constants for the decode stage and its field extractor.
package risc_pkg;

  localparam int REG_W   = 3;
  localparam int NREGS   = 8;
  localparam int INSN_W  = 16;

  localparam int OP_LSB  = 13;
  localparam int RA_LSB  = 10;
  localparam int RB_LSB  = 7;
  localparam int RC_LSB  = 0;
  localparam int SIMM_W  = 7;
  localparam int IMM10_W = 10;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADDI = 3'b001,
    OP_NAND = 3'b010,
    OP_LUI  = 3'b011,
    OP_SW   = 3'b100,
    OP_LW   = 3'b101,
    OP_BEQ  = 3'b110,
    OP_JALR = 3'b111
  } opcode_e;

endpackage

// File: rtl/risc_insn_fields.sv
// Combinational RiSC-16 field split: opcode, registers, operand usage and the
// immediate extended to XLEN bits.
module risc_insn_fields
  import risc_pkg::*;
#(
  parameter int XLEN = 16
) (
  input  logic [INSN_W-1:0] instr,
  output opcode_e           op,
  output logic [REG_W-1:0]  ra,
  output logic [REG_W-1:0]  rb,
  output logic [REG_W-1:0]  rs2,
  output logic              rs1_use,
  output logic              rs2_use,
  output logic              writes,
  output logic [XLEN-1:0]   imm
);

  logic [XLEN-1:0] simm_ext;
  logic [XLEN-1:0] lui_ext;

  assign op       = opcode_e'(instr[OP_LSB +: 3]);
  assign ra       = instr[RA_LSB +: REG_W];
  assign rb       = instr[RB_LSB +: REG_W];
  assign simm_ext = {{(XLEN-SIMM_W){instr[SIMM_W-1]}}, instr[SIMM_W-1:0]};
  assign lui_ext  = {instr[IMM10_W-1:0], {(XLEN-IMM10_W){1'b0}}};

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    rs2     = instr[RC_LSB +: REG_W];
    rs1_use = 1'b1;
    rs2_use = 1'b0;
    writes  = 1'b1;
    imm     = '0;
    unique case (op)
      OP_ADD, OP_NAND: rs2_use = 1'b1;
      OP_ADDI, OP_LW, OP_JALR: imm = simm_ext;
      OP_LUI: begin
        rs1_use = 1'b0;
        imm     = lui_ext;
      end
      OP_SW, OP_BEQ: begin
        rs2     = ra;
        rs2_use = 1'b1;
        writes  = 1'b0;
        imm     = simm_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/risc_decode_stage.sv
// Registered RiSC-16 decode stage with a write scoreboard that stalls RAW/WAW
// hazards, valid/ready on both sides and a pipeline flush.
module risc_decode_stage
  import risc_pkg::*;
#(
  parameter int XLEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSN_W-1:0] in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [2:0]        out_op,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_rd_we,
  output logic [REG_W-1:0]  out_rs1,
  output logic [REG_W-1:0]  out_rs2,
  output logic              out_rs2_use,
  output logic [XLEN-1:0]   out_imm,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic              flush
);

  opcode_e          f_op;
  logic [REG_W-1:0] f_ra, f_rb, f_rs2;
  logic             f_rs1_use, f_rs2_use, f_writes, f_rd_we;
  logic [XLEN-1:0]  f_imm;

  logic [NREGS-1:0] pend, pend_clr, pend_next;
  logic             hazard, accept;

  risc_insn_fields #(.XLEN(XLEN)) u_fields (
    .instr   (in_instr),
    .op      (f_op),
    .ra      (f_ra),
    .rb      (f_rb),
    .rs2     (f_rs2),
    .rs1_use (f_rs1_use),
    .rs2_use (f_rs2_use),
    .writes  (f_writes),
    .imm     (f_imm)
  );

  assign f_rd_we = f_writes && (f_ra != '0);

  // Same-cycle writeback is visible to the hazard check, so a retiring
  // producer unblocks its consumer without a bubble.
  always_comb begin
    pend_clr = pend;
    if (wb_valid) pend_clr[wb_reg] = 1'b0;
  end

  // r0 is never marked pending, so zero sources and destinations never stall.
  assign hazard = in_valid && ((f_rs1_use && pend_clr[f_rb])  ||
                               (f_rs2_use && pend_clr[f_rs2]) ||
                               (f_writes  && pend_clr[f_ra]));

  assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // A flushed entry that was never consumed will never write back; the WAW
  // stall guarantees it is the only writer of that register in flight.
  always_comb begin
    pend_next = pend_clr;
    if (flush && out_valid && out_rd_we && !out_ready) pend_next[out_rd] = 1'b0;
    if (accept && f_rd_we) pend_next[f_ra] = 1'b1;
    pend_next[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend        <= '0;
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_op      <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rs2_use <= 1'b0;
      out_imm     <= '0;
    end else begin
      pend <= pend_next;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_pc      <= in_pc;
        out_op      <= f_op;
        out_rd      <= f_ra;
        out_rd_we   <= f_rd_we;
        out_rs1     <= f_rb;
        out_rs2     <= f_rs2;
        out_rs2_use <= f_rs2_use;
        out_imm     <= f_imm;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_risc_decode_stage.sv
// Self-checking bench: directed scenarios from the RiSC-16 decode rules plus a
// randomized run scored against a behavioural model of the stage.
module tb_risc_decode_stage;

  localparam int XLEN = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic        out_ready;
  logic        wb_valid;
  logic [2:0]  wb_reg;
  logic        flush;

  logic        in_ready, out_valid, out_rd_we, out_rs2_use;
  logic [15:0] out_pc, out_imm;
  logic [2:0]  out_op, out_rd, out_rs1, out_rs2;

  logic        in_ready32, out_valid32, out_rd_we32, out_rs2_use32;
  logic [31:0] out_pc32, out_imm32;
  logic [2:0]  out_op32, out_rd32, out_rs132, out_rs232;
  logic [31:0] in_pc32;

  int n_checks = 0;
  int n_fail   = 0;

  assign in_pc32 = {16'h0, in_pc};

  always #5 clk = ~clk;

  risc_decode_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rs2_use(out_rs2_use), .out_imm(out_imm), .wb_valid(wb_valid),
    .wb_reg(wb_reg), .flush(flush)
  );

  risc_decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(in_pc32), .out_valid(out_valid32),
    .out_ready(out_ready), .out_pc(out_pc32), .out_op(out_op32),
    .out_rd(out_rd32), .out_rd_we(out_rd_we32), .out_rs1(out_rs132),
    .out_rs2(out_rs232), .out_rs2_use(out_rs2_use32), .out_imm(out_imm32),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush)
  );

  typedef struct {
    bit [2:0]  op, rd, rs1, rs2;
    bit        rs1_use, rs2_use, writes;
    bit [15:0] imm;
  } dec_t;

  function automatic dec_t decode(bit [15:0] i);
    dec_t d;
    int   s;
    int   u;
    d.op  = i[15:13];
    d.rd  = i[12:10];
    d.rs1 = i[9:7];
    d.rs2 = i[2:0];
    d.rs1_use = 1; d.rs2_use = 0; d.writes = 1; d.imm = 0;
    s = int'(i[6:0]);
    if (s >= 64) s = s - 128;
    u = int'(i[9:0]) * 64;
    case (d.op)
      3'd0, 3'd2: d.rs2_use = 1;
      3'd1, 3'd5, 3'd7: d.imm = 16'(s);
      3'd3: begin d.rs1_use = 0; d.imm = 16'(u); end
      default: begin
        d.rs2 = d.rd; d.rs2_use = 1; d.writes = 0; d.imm = 16'(s);
      end
    endcase
    return d;
  endfunction

  task automatic apply(input bit iv, input bit [15:0] ins, input bit [15:0] pc,
                       input bit ord, input bit wbv, input bit [2:0] wbr,
                       input bit fl);
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ord;
    wb_valid = wbv; wb_reg = wbr; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    apply(1, 16'h0503, 16'h1234, 1, 1, 3'd3, 0);
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_checks++; if ({out_op, out_rd, out_rs1, out_rs2} !== 12'h0) begin n_fail++; $display("FAIL reset_regs got %h want 000", {out_op, out_rd, out_rs1, out_rs2}); end
    n_checks++; if ({out_pc, out_imm, out_rd_we, out_rs2_use} !== 34'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", {out_pc, out_imm, out_rd_we, out_rs2_use}); end
    n_checks++; if (dut.pend !== 8'h00) begin n_fail++; $display("FAIL reset_pend got %h want 00", dut.pend); end
    rst = 0;
    apply(0, 0, 0, 1, 0, 0, 0);
    tick();
  endtask

  task automatic test_add_raw();
    apply(1, 16'h0503, 16'h0010, 1, 0, 0, 0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready got %0b want 1", in_ready); end
    tick();
    n_checks++; if ({out_valid, out_op, out_rd, out_rs1, out_rs2, out_rs2_use, out_rd_we} !== {1'b1, 3'd0, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1})
      begin n_fail++; $display("FAIL add_fields got v%0b op%0d rd%0d rs1%0d rs2%0d u%0b we%0b", out_valid, out_op, out_rd, out_rs1, out_rs2, out_rs2_use, out_rd_we); end
    n_checks++; if ({out_imm, out_pc} !== {16'h0000, 16'h0010}) begin n_fail++; $display("FAIL add_imm_pc got %h %h want 0000 0010", out_imm, out_pc); end
    n_checks++; if (dut.pend !== 8'h02) begin n_fail++; $display("FAIL add_pend got %h want 02", dut.pend); end
    apply(1, 16'h28FF, 16'h0011, 1, 0, 0, 0);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall got %0b want 0", in_ready); end
    tick();
    n_checks++; if ({in_ready, out_valid} !== 2'b00) begin n_fail++; $display("FAIL raw_stall2 got %b want 00", {in_ready, out_valid}); end
    apply(1, 16'h28FF, 16'h0011, 1, 1, 3'd1, 0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_wb_unblock got %0b want 1", in_ready); end
    tick();
    n_checks++; if ({out_valid, out_rd, out_rs1, out_rs2_use, out_rd_we, out_imm} !== {1'b1, 3'd2, 3'd1, 1'b0, 1'b1, 16'hFFFF})
      begin n_fail++; $display("FAIL addi_fields got v%0b rd%0d rs1%0d u%0b we%0b imm%h", out_valid, out_rd, out_rs1, out_rs2_use, out_rd_we, out_imm); end
    n_checks++; if (dut.pend !== 8'h04) begin n_fail++; $display("FAIL addi_pend got %h want 04", dut.pend); end
    apply(0, 0, 0, 1, 1, 3'd2, 0);
    tick();
  endtask

  task automatic test_lui();
    apply(1, 16'h6FFF, 16'h0020, 1, 0, 0, 0);
    tick();
    n_checks++; if (out_imm !== 16'hFFC0) begin n_fail++; $display("FAIL lui_imm16 got %h want ffc0", out_imm); end
    n_checks++; if (out_imm32 !== 32'hFFC00000) begin n_fail++; $display("FAIL lui_imm32 got %h want ffc00000", out_imm32); end
    n_checks++; if ({out_op, out_rd, out_rd_we, out_rs2_use} !== {3'd3, 3'd3, 1'b1, 1'b0}) begin n_fail++; $display("FAIL lui_fields got op%0d rd%0d we%0b u%0b", out_op, out_rd, out_rd_we, out_rs2_use); end
    n_checks++; if (dut.pend !== 8'h08) begin n_fail++; $display("FAIL lui_pend got %h want 08", dut.pend); end
    apply(0, 0, 0, 1, 1, 3'd3, 0);
    tick();
  endtask

  task automatic test_beq();
    apply(1, 16'h0503, 16'h0030, 1, 0, 0, 0);
    tick();
    apply(1, 16'hC001, 16'h0031, 1, 0, 0, 0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL beq_ready got %0b want 1", in_ready); end
    tick();
    n_checks++; if ({out_valid, out_op, out_rd_we, out_rs2_use, out_imm} !== {1'b1, 3'd6, 1'b0, 1'b1, 16'h0001})
      begin n_fail++; $display("FAIL beq_fields got v%0b op%0d we%0b u%0b imm%h", out_valid, out_op, out_rd_we, out_rs2_use, out_imm); end
    n_checks++; if (dut.pend !== 8'h02) begin n_fail++; $display("FAIL beq_pend got %h want 02", dut.pend); end
    apply(0, 0, 0, 1, 1, 3'd1, 0);
    tick();
  endtask

  task automatic test_flush();
    apply(1, 16'h0503, 16'h0040, 0, 0, 0, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    tick();
    n_checks++; if ({out_valid, out_pc, out_rd} !== {1'b1, 16'h0040, 3'd1}) begin n_fail++; $display("FAIL flush_hold got v%0b pc%h rd%0d", out_valid, out_pc, out_rd); end
    apply(1, 16'h0503, 16'h0041, 0, 0, 0, 1);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %0b want 0", in_ready); end
    tick();
    n_checks++; if ({out_valid, dut.pend} !== {1'b0, 8'h00}) begin n_fail++; $display("FAIL flush_clear got v%0b pend%h want 0 00", out_valid, dut.pend); end
    apply(1, 16'h0503, 16'h0042, 0, 0, 0, 0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_reissue got %0b want 1", in_ready); end
    tick();
    apply(0, 0, 0, 1, 0, 0, 1);
    tick();
    n_checks++; if ({out_valid, dut.pend} !== {1'b0, 8'h02}) begin n_fail++; $display("FAIL flush_consumed got v%0b pend%h want 0 02", out_valid, dut.pend); end
    apply(0, 0, 0, 1, 1, 3'd1, 0);
    tick();
  endtask

  task automatic test_back_to_back();
    apply(1, 16'h0400, 16'h0050, 1, 0, 0, 0);
    tick();
    n_checks++; if ({out_valid, out_rd, out_pc} !== {1'b1, 3'd1, 16'h0050}) begin n_fail++; $display("FAIL b2b_first got v%0b rd%0d pc%h", out_valid, out_rd, out_pc); end
    apply(1, 16'h0800, 16'h0051, 0, 0, 0, 0);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_bp_ready got %0b want 0", in_ready); end
    tick();
    n_checks++; if ({out_valid, out_rd, out_pc} !== {1'b1, 3'd1, 16'h0050}) begin n_fail++; $display("FAIL b2b_stable got v%0b rd%0d pc%h", out_valid, out_rd, out_pc); end
    apply(1, 16'h0800, 16'h0051, 1, 0, 0, 0);
    tick();
    n_checks++; if ({out_valid, out_rd, out_pc} !== {1'b1, 3'd2, 16'h0051}) begin n_fail++; $display("FAIL b2b_second got v%0b rd%0d pc%h", out_valid, out_rd, out_pc); end
    apply(1, 16'h0C00, 16'h0052, 1, 0, 0, 0);
    tick();
    n_checks++; if ({out_valid, out_rd, dut.pend} !== {1'b1, 3'd3, 8'h0E}) begin n_fail++; $display("FAIL b2b_third got v%0b rd%0d pend%h", out_valid, out_rd, dut.pend); end
  endtask

  task automatic test_random();
    dec_t      m_d, d;
    bit        m_valid = 0;
    bit [15:0] m_pc = 0;
    bit [7:0]  m_pend = 0, pp, np;
    rst = 1;
    apply(0, 0, 0, 1, 0, 0, 0);
    tick();
    rst = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit iv, ord, fl, wbv, haz, exp_ready, acc;
      bit [15:0] ins, pc;
      bit [2:0] wbr;
      int pend_list[$];
      iv  = $urandom_range(0, 9) < 7;
      ins = 16'($urandom);
      pc  = 16'($urandom);
      ord = $urandom_range(0, 9) < 7;
      fl  = $urandom_range(0, 19) == 0;
      for (int r = 1; r < 8; r++) if (m_pend[r]) pend_list.push_back(r);
      if (pend_list.size() > 0 && $urandom_range(0, 9) < 5) begin
        wbv = 1;
        wbr = 3'(pend_list[$urandom_range(0, pend_list.size() - 1)]);
      end else begin
        wbv = $urandom_range(0, 9) == 0;
        wbr = 3'($urandom_range(0, 7));
      end
      apply(iv, ins, pc, ord, wbv, wbr, fl);

      pp = m_pend;
      if (wbv) pp[wbr] = 0;
      d = decode(ins);
      haz = iv && ((d.rs1_use && pp[d.rs1]) || (d.rs2_use && pp[d.rs2]) || (d.writes && pp[d.rd]));
      exp_ready = !haz && (!m_valid || ord) && !fl;
      n_checks++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready cyc%0d got %0b want %0b", cyc, in_ready, exp_ready); end
      acc = iv && exp_ready;
      np = pp;
      if (fl && m_valid && m_d.writes && m_d.rd != 0 && !ord) np[m_d.rd] = 0;
      if (acc && d.writes && d.rd != 0) np[d.rd] = 1;
      if (fl) m_valid = 0;
      else if (acc) begin m_valid = 1; m_d = d; m_pc = pc; end
      else if (ord) m_valid = 0;
      m_pend = np;

      tick();
      n_checks++; if (out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid cyc%0d got %0b want %0b", cyc, out_valid, m_valid); end
      n_checks++; if (dut.pend !== m_pend) begin n_fail++; $display("FAIL rnd_pend cyc%0d got %h want %h", cyc, dut.pend, m_pend); end
      if (m_valid) begin
        n_checks++;
        if ({out_pc, out_op, out_rd, out_rs1, out_imm} !== {m_pc, m_d.op, m_d.rd, m_d.rs1, m_d.imm})
          begin n_fail++; $display("FAIL rnd_fields cyc%0d got pc%h op%0d rd%0d rs1%0d imm%h want pc%h op%0d rd%0d rs1%0d imm%h", cyc, out_pc, out_op, out_rd, out_rs1, out_imm, m_pc, m_d.op, m_d.rd, m_d.rs1, m_d.imm); end
        n_checks++;
        if ({out_rd_we, out_rs2_use} !== {m_d.writes && m_d.rd != 0, m_d.rs2_use})
          begin n_fail++; $display("FAIL rnd_flags cyc%0d got we%0b u%0b want we%0b u%0b", cyc, out_rd_we, out_rs2_use, m_d.writes && m_d.rd != 0, m_d.rs2_use); end
        if (m_d.rs2_use) begin
          n_checks++; if (out_rs2 !== m_d.rs2) begin n_fail++; $display("FAIL rnd_rs2 cyc%0d got %0d want %0d", cyc, out_rs2, m_d.rs2); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_raw();
    test_lui();
    test_beq();
    test_flush();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
